// File: rtl/stn_pkg.sv
// Shared defaults, status record and parameter legality helper for the
// STN panel capture block.
package stn_pkg;

  localparam int DW_DEF         = 4;
  localparam int AW_DEF         = 13;
  localparam int LINE_BYTES_DEF = 40;
  localparam int LINES_DEF      = 120;
  localparam int FIRST_LINE_DEF = 1;

  typedef struct packed {
    logic ovr;
    logic lng;
    logic shrt;
  } stat_t;

  // Panel data buses come only as 4- or 8-bit, so a byte is 2 or 1 shifts.
  function automatic bit dw_legal(input int dw);
    return (dw == 4) || (dw == 8);
  endfunction

endpackage

// File: rtl/stn_sync.sv
// Two-flop synchroniser with a history flop; fall is high for exactly one
// cycle, consumed on the third clk edge after the pin falls.
module stn_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic lvl,
  output logic fall
);

  // pipe[1:0] synchronise, pipe[2] is the previous synced value
  logic [2:0] pipe;

  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[1:0], pin};
  end

  assign lvl  = pipe[1];
  assign fall = pipe[2] & ~pipe[1];

endmodule

// File: rtl/stn_capture.sv
// STN panel capture: resynchronises panel timing pins, packs shift samples
// into bytes and writes them to a line-addressed buffer with sticky status.
module stn_capture
  import stn_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int LINES      = LINES_DEF,
  parameter int FIRST_LINE = FIRST_LINE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stn_fpframe,
  input  logic          stn_fpline,
  input  logic          stn_fpshift,
  input  logic [DW-1:0] stn_fpdat,
  output logic          fifo_wrreq,
  input  logic          fifo_wrack,
  output logic [AW-1:0] fifo_waddr,
  output logic [7:0]    fifo_wdata,
  input  logic          stat_clr,
  output logic          stat_ovr,
  output logic          stat_long,
  output logic          stat_short,
  output logic          frame_pulse
);

  localparam int NPACK = 8 / DW;
  localparam int PCW   = (NPACK > 1) ? $clog2(NPACK) : 1;
  localparam int BCW   = $clog2(LINE_BYTES + 1);
  localparam int LIW   = (LINES > 1) ? $clog2(LINES) : 1;

  if (!dw_legal(DW)) begin : g_bad_dw
    $error("stn_capture: DW must be 4 or 8");
  end
  if (LINE_BYTES * LINES > (2 ** AW)) begin : g_bad_aw
    $error("stn_capture: LINE_BYTES*LINES exceeds the buffer address space");
  end

  // index 0 = fpshift, 1 = fpline, 2 = fpframe
  logic [2:0] lvl, fall;
  logic       unused_sync;

  stn_sync u_sync [2:0] (
    .clk  (clk),
    .rst  (rst),
    .pin  ({stn_fpframe, stn_fpline, stn_fpshift}),
    .lvl  (lvl),
    .fall (fall)
  );

  assign unused_sync = ^{lvl[1:0], fall[2]};

  logic shift_fall, line_fall, frame_lvl;
  assign shift_fall = fall[0];
  assign line_fall  = fall[1];
  assign frame_lvl  = lvl[2];

  // Data takes the same two-flop path so it lines up with the shift pulse.
  logic [DW-1:0] dat_s1, dat_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_s1 <= '0;
      dat_s2 <= '0;
    end else begin
      dat_s1 <= stn_fpdat;
      dat_s2 <= dat_s1;
    end
  end

  logic [7:0]     acc, acc_n;
  logic [PCW-1:0] pack_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [LIW-1:0] line_idx, line_idx_n;
  logic [AW-1:0]  waddr_n;
  logic           sample, byte_done, room, blocked;
  logic           accept, drop_ovr, drop_long, short_evt;
  stat_t          stat, stat_n;

  // A line end in the same cycle as a shift wins; that sample is lost.
  assign sample    = shift_fall & ~line_fall;
  assign acc_n     = 8'({acc, dat_s2});
  assign byte_done = sample & (pack_cnt == PCW'(NPACK - 1));
  assign room      = byte_cnt < BCW'(LINE_BYTES);
  assign blocked   = fifo_wrreq & ~fifo_wrack;
  assign accept    = byte_done & room & ~blocked;
  assign drop_ovr  = byte_done & room & blocked;
  assign drop_long = byte_done & ~room;
  assign short_evt = line_fall & ~frame_lvl & room & (byte_cnt != '0);
  assign waddr_n   = AW'(line_idx) * AW'(LINE_BYTES) + AW'(byte_cnt);

  always_comb begin
    line_idx_n = line_idx;
    if (line_fall) begin
      if (frame_lvl)                          line_idx_n = LIW'(FIRST_LINE);
      else if (line_idx == LIW'(LINES - 1))   line_idx_n = '0;
      else                                    line_idx_n = line_idx + 1'b1;
    end
  end

  // Clear first so a same-cycle set event survives.
  always_comb begin
    stat_n = stat_clr ? '0 : stat;
    if (drop_ovr)  stat_n.ovr  = 1'b1;
    if (drop_long) stat_n.lng  = 1'b1;
    if (short_evt) stat_n.shrt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      pack_cnt    <= '0;
      byte_cnt    <= '0;
      line_idx    <= '0;
      fifo_wrreq  <= 1'b0;
      fifo_waddr  <= '0;
      fifo_wdata  <= '0;
      stat        <= '0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= line_fall & frame_lvl;
      line_idx    <= line_idx_n;
      stat        <= stat_n;

      if (line_fall) begin
        pack_cnt <= '0;
        byte_cnt <= '0;
      end else if (sample) begin
        acc      <= acc_n;
        pack_cnt <= byte_done ? '0 : pack_cnt + 1'b1;
        // Overrun drops still consume their slot so later bytes keep position.
        if (byte_done && room) byte_cnt <= byte_cnt + 1'b1;
      end

      if (accept) begin
        fifo_wrreq <= 1'b1;
        fifo_waddr <= waddr_n;
        fifo_wdata <= acc_n;
      end else if (fifo_wrreq && fifo_wrack) begin
        fifo_wrreq <= 1'b0;
      end
    end
  end

  assign stat_ovr   = stat.ovr;
  assign stat_long  = stat.lng;
  assign stat_short = stat.shrt;

endmodule

// File: tb/tb_stn_capture.sv
// Directed bench for stn_capture: a DW=4 and a DW=8 instance, with a
// queue scoreboard popped by per-instance write-port monitors.
module tb_stn_capture;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] fpframe, fpline, fpshift;
  logic [3:0] dat4;
  logic [7:0] dat8;
  logic       stat_clr;
  logic [1:0] stall;

  logic        wrreq4, wrack4 = 1'b0, ovr4, long4, short4, fp4;
  logic [12:0] waddr4;
  logic [7:0]  wdata4;
  logic        wrreq8, wrack8 = 1'b0, ovr8, long8, short8, fp8;
  logic [12:0] waddr8;
  logic [7:0]  wdata8;

  wr_t q4[$], q8[$];
  int  n_cmp = 0, n_err = 0;
  int  wr4 = 0, wr8 = 0, fpc4 = 0, fpc8 = 0;

  stn_capture #(.DW(4)) u_dut4 (
    .clk(clk), .rst(rst), .stn_fpframe(fpframe[0]), .stn_fpline(fpline[0]),
    .stn_fpshift(fpshift[0]), .stn_fpdat(dat4), .fifo_wrreq(wrreq4),
    .fifo_wrack(wrack4), .fifo_waddr(waddr4), .fifo_wdata(wdata4),
    .stat_clr(stat_clr), .stat_ovr(ovr4), .stat_long(long4),
    .stat_short(short4), .frame_pulse(fp4)
  );

  stn_capture #(.DW(8)) u_dut8 (
    .clk(clk), .rst(rst), .stn_fpframe(fpframe[1]), .stn_fpline(fpline[1]),
    .stn_fpshift(fpshift[1]), .stn_fpdat(dat8), .fifo_wrreq(wrreq8),
    .fifo_wrack(wrack8), .fifo_waddr(waddr8), .fifo_wdata(wdata8),
    .stat_clr(stat_clr), .stat_ovr(ovr8), .stat_long(long8),
    .stat_short(short8), .frame_pulse(fp8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitors: ack every presented request unless stalled, pop and compare.
  always @(negedge clk) begin
    if (rst) wrack4 = 1'b0;
    else if (wrreq4 && !stall[0]) begin
      wr4++;
      if (q4.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wr4_unexpected: got addr %0d data %0h want none", waddr4, wdata4);
      end else begin
        wr_t e;
        e = q4.pop_front();
        chk("wr4_addr_data", 32'({waddr4, wdata4}), 32'(e));
      end
      wrack4 = 1'b1;
    end else wrack4 = 1'b0;
    if (fp4) fpc4++;
  end

  always @(negedge clk) begin
    if (rst) wrack8 = 1'b0;
    else if (wrreq8 && !stall[1]) begin
      wr8++;
      if (q8.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wr8_unexpected: got addr %0d data %0h want none", waddr8, wdata8);
      end else begin
        wr_t e;
        e = q8.pop_front();
        chk("wr8_addr_data", 32'({waddr8, wdata8}), 32'(e));
      end
      wrack8 = 1'b1;
    end else wrack8 = 1'b0;
    if (fp8) fpc8++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift(input int s, input logic [7:0] d);
    if (s == 0) dat4 = d[3:0];
    else        dat8 = d;
    fpshift[s] = 1'b1; cyc(4);
    fpshift[s] = 1'b0; cyc(4);
  endtask

  task automatic byte4(input logic [7:0] d);
    shift(0, {4'h0, d[7:4]});
    shift(0, {4'h0, d[3:0]});
  endtask

  task automatic line_end(input int s, input logic f);
    fpframe[s] = f; fpline[s] = 1'b1; cyc(4);
    fpline[s] = 1'b0; cyc(5);
    fpframe[s] = 1'b0; cyc(3);
  endtask

  task automatic push4(input int a, input logic [7:0] d);
    q4.push_back(wr_t'{addr: 13'(a), data: d});
  endtask

  task automatic push8(input int a, input logic [7:0] d);
    q8.push_back(wr_t'{addr: 13'(a), data: d});
  endtask

  task automatic drain(input int s);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (s == 0) done = (q4.size() == 0) && !wrreq4;
      else        done = (q8.size() == 0) && !wrreq8;
      if (!done) cyc(1);
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL drain%0d: got pending writes want none", s);
    end
  endtask

  task automatic clr_pulse();
    stat_clr = 1'b1; cyc(1); stat_clr = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k * 37 + 5);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fpframe = '0; fpline = '0; fpshift = '0;
    dat4 = '0; dat8 = '0; stat_clr = 1'b0; stall = '0;
    cyc(3);
    chk("rst_wrreq", 32'(wrreq4), 0);
    chk("rst_waddr", 32'(waddr4), 0);
    chk("rst_wdata", 32'(wdata4), 0);
    chk("rst_stat", 32'({ovr4, long4, short4}), 0);
    chk("rst_frame_pulse", 32'(fp4), 0);
    rst = 1'b0; cyc(4);

    // Frame-tagged line loads line 1, then a full 40-byte line.
    line_end(0, 1'b1);
    chk("frame_pulse_count", 32'(fpc4), 1);
    for (int k = 0; k < 40; k++) begin
      push4(40 + k, pat(k));
      byte4(pat(k));
    end
    line_end(0, 1'b0);
    drain(0);
    chk("full_line_writes", 32'(wr4), 40);
    chk("full_line_stat", 32'({ovr4, long4, short4}), 0);
    chk("no_frame_pulse_plain", 32'(fpc4), 1);

    // Line 2: 42 bytes, last two dropped as too long.
    for (int k = 0; k < 42; k++) begin
      if (k < 40) push4(80 + k, pat(k + 50));
      byte4(pat(k + 50));
    end
    line_end(0, 1'b0);
    drain(0);
    chk("long_writes", 32'(wr4), 80);
    chk("long_flag", 32'(long4), 1);
    chk("long_no_short", 32'(short4), 0);

    // Line 3: 30 bytes, short.
    for (int k = 0; k < 30; k++) begin
      push4(120 + k, pat(k + 150));
      byte4(pat(k + 150));
    end
    line_end(0, 1'b0);
    drain(0);
    chk("short_writes", 32'(wr4), 110);
    chk("short_flag", 32'(short4), 1);
    clr_pulse();
    chk("clr_stat", 32'({ovr4, long4, short4}), 0);

    // Line 4: write stalled across a second byte -> overrun drop.
    stall[0] = 1'b1;
    push4(160, pat(100));
    byte4(pat(100));
    chk("stall_wrreq", 32'(wrreq4), 1);
    byte4(pat(101));
    chk("ovr_flag", 32'(ovr4), 1);
    chk("stall_addr_held", 32'(waddr4), 160);
    chk("stall_data_held", 32'(wdata4), 32'(pat(100)));
    stall[0] = 1'b0;
    cyc(3);
    chk("stall_released_writes", 32'(wr4), 111);
    push4(162, pat(102));
    byte4(pat(102));
    line_end(0, 1'b0);
    drain(0);
    chk("after_ovr_writes", 32'(wr4), 112);
    clr_pulse();

    // Line 5: one nibble then line end coinciding with a shift edge.
    shift(0, 8'h0A);
    dat4 = 4'h5;
    fpshift[0] = 1'b1; fpline[0] = 1'b1; cyc(4);
    fpshift[0] = 1'b0; fpline[0] = 1'b0; cyc(8);
    chk("partial_no_write", 32'(wr4), 112);
    chk("partial_no_short", 32'(short4), 0);
    push4(240, 8'h3C);
    byte4(8'h3C);
    line_end(0, 1'b0);
    drain(0);
    chk("post_partial_writes", 32'(wr4), 113);
    chk("one_byte_short", 32'(short4), 1);

    // DW=8 instance: walk to line 119, then wrap to line 0.
    line_end(1, 1'b1);
    for (int i = 0; i < 118; i++) line_end(1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push8(4760 + k, pat(k + 200));
      shift(1, pat(k + 200));
    end
    line_end(1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push8(k, pat(k + 210));
      shift(1, pat(k + 210));
    end
    line_end(1, 1'b0);
    drain(1);
    chk("dw8_writes", 32'(wr8), 6);
    chk("dw8_frame_pulses", 32'(fpc8), 1);

    // Reset while a request is pending.
    stall[0] = 1'b1;
    byte4(pat(7));
    chk("pre_rst_wrreq", 32'(wrreq4), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_pending_wrreq", 32'(wrreq4), 0);
    chk("rst_pending_waddr", 32'(waddr4), 0);
    @(negedge clk);
    rst = 1'b0; stall = '0;
    cyc(4);
    chk("final_q4_empty", 32'(q4.size()), 0);
    chk("final_q8_empty", 32'(q8.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stn_capture.md
STN_CAPTURE -- requirements
Module: stn_capture

Interface
REQ-001 SHALL have parameter DW, default 4: panel data bits per FPSHIFT, legal values 4 or 8.
REQ-002 SHALL have parameter AW, default 13: buffer address width.
REQ-003 SHALL have parameter LINE_BYTES, default 40: bytes per panel line.
REQ-004 SHALL have parameter LINES, default 120: lines per frame.
REQ-005 SHALL have parameter FIRST_LINE, default 1: line index loaded by a frame-tagged line end.
REQ-006 SHALL have the following ports (clock and reset first):
  clk  in  1  single clock
  rst  in  1  reset, synchronous, active-high
  stn_fpframe  in  1  panel frame, asynchronous
  stn_fpline  in  1  panel line, asynchronous
  stn_fpshift  in  1  panel shift clock, asynchronous
  stn_fpdat  in  DW  panel data
  fifo_wrreq  out  1  write request
  fifo_wrack  in  1  write acknowledge
  fifo_waddr  out  AW  write address
  fifo_wdata  out  8  write data
  stat_clr  in  1  clears sticky status
  stat_ovr  out  1  sticky: byte dropped because a write was still pending
  stat_long  out  1  sticky: line exceeded LINE_BYTES
  stat_short  out  1  sticky: line ended with fewer than LINE_BYTES bytes
  frame_pulse  out  1  one-cycle pulse on a frame-tagged line end

Function
REQ-007 SHALL synchronise fpframe, fpline and fpshift through two flops, then one history flop.
REQ-008 SHALL detect an edge as history=1 and synced=0 (falling edge); edge pulses SHALL last one cycle, 3 cycles after the pin edge.
REQ-009 SHALL sample fpdat on each fpshift falling-edge pulse, captured from the synced path so it aligns with that edge.
REQ-010 SHALL pack 8/DW samples per byte, MSB-first: DW=4 fills [7:4] then [3:0]; DW=8 completes a byte on every sample.
REQ-011 SHALL keep a line byte counter, cleared at line end, incremented per completed byte, saturating at LINE_BYTES.
REQ-012 SHALL hand a completed byte to the write port when counter<LINE_BYTES; otherwise it SHALL drop the byte and set stat_long.
REQ-013 SHALL compute write address = line_index*LINE_BYTES + byte_count, latched into fifo_waddr and fifo_wdata at the request.
REQ-014 SHALL raise fifo_wrreq the cycle after a byte completes and hold it, with address and data stable, until fifo_wrack; wrreq SHALL fall the cycle after wrack.
REQ-015 SHALL ignore fifo_wrack while fifo_wrreq=0.
REQ-016 SHALL drop a byte that completes while wrreq=1 and wrack=0, and set stat_ovr; wrack and a new byte in the same cycle SHALL be accepted without overrun.
REQ-017 SHALL handle a line end (fpline falling edge pulse) as follows:
  - set stat_short if byte counter<LINE_BYTES and byte counter>0;
  - clear the pack counter, discarding any partial byte;
  - clear the byte counter;
  - advance line_index, wrapping LINES-1 -> 0.
REQ-018 SHALL, on a line end with synced fpframe=1, load line_index := FIRST_LINE and pulse frame_pulse; stat_short SHALL be suppressed for that line.
REQ-019 SHALL give the line end priority over a shift edge in the same cycle; that shift sample is discarded.
REQ-020 SHALL let a write pending at a line end complete with its latched address.
REQ-021 SHALL clear all sticky flags on stat_clr; a set event in the same cycle SHALL win.
REQ-022 SHALL require LINE_BYTES*LINES <= 2^AW, checked at elaboration.

Reset
REQ-023 SHALL, on rst=1 at a clk edge, clear all flops to 0: fifo_wrreq=0, fifo_waddr=0, fifo_wdata=0, all stat_*=0, frame_pulse=0, line_index=0.
REQ-024 SHALL, on reset during a pending write, drop wrreq without waiting for wrack.
REQ-025 SHALL take 3 cycles after reset release before edge detection becomes valid; no false edge SHALL be generated.

Structure
REQ-026 SHALL place parameter defaults and the DW legality check in shared package stn_pkg.
REQ-027 SHALL use sub-module stn_sync (2-flop sync plus falling-edge pulse), instantiated for fpframe, fpline and fpshift.

Verification
REQ-028 SHALL cover: DW=4, one frame-tagged line, then a line of 80 shifts with no wrack stall -> 40 writes at addresses 40..79, data matching nibble pairs, no status set.
REQ-029 SHALL cover: DW=8, line index 119 of 120 -> next line writes start at address 0 (wrap).
REQ-030 SHALL cover: wrack withheld for 2 byte times -> one byte dropped, stat_ovr=1, first request address unchanged.
REQ-031 SHALL cover: 84 shifts on one line (DW=4) -> 40 writes, stat_long=1; then 60 shifts -> stat_short=1; then stat_clr -> all flags 0.
REQ-032 SHALL cover: fpline falling edge on the same cycle as a shift edge after 1 nibble -> partial byte discarded, no write.
REQ-033 SHALL cover: rst asserted with wrreq=1 -> wrreq=0 the next cycle, waddr=0.
